// File: rtl/dealignment_collector_n4_w4.sv
// Lane de-alignment collector: drains one lane's output alignment FIFO byte
// by byte, drops the leading skew bytes of each frame and reassembles the
// data bytes (first byte in the least significant position) into one word
// that is offered on a valid/ready interface.
module dealignment_collector_n4_w4 #(
  parameter int SKEW  = 3,
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               fifo_empty,
  input  logic [7:0]         fifo_data,
  output logic               fifo_re,
  output logic [8*BYTES-1:0] word_data,
  output logic               word_valid,
  input  logic               word_ready,
  output logic               busy,
  output logic               done
);

  localparam int TOTAL = SKEW + BYTES;
  localparam int CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;   // reads issued this frame
  logic [CNT_W-1:0]   bidx_q, bidx_d;       // bytes captured this frame
  logic               rd_pend_q, rd_pend_d; // a read was issued last cycle
  logic [8*BYTES-1:0] word_q, word_d;
  logic               done_q, done_d;

  // State register and datapath registers; reset discards any partial frame.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values computed before this edge, independent of
  // statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      bidx_q    <= '0;
      rd_pend_q <= 1'b0;
      word_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      bidx_q    <= bidx_d;
      rd_pend_q <= rd_pend_d;
      word_q    <= word_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: read issue, byte capture and the valid/ready handshake.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    done_d   = 1'b0;

    // Reads stop once the whole frame has been requested; an empty FIFO only
    // stalls issue, captures already in flight still complete.
    fifo_re   = (state_q == ST_COLLECT) && !fifo_empty &&
                (rd_cnt_q < CNT_W'(TOTAL));
    rd_pend_d = fifo_re;

    case (state_q)
      ST_IDLE: begin
        rd_cnt_d = '0;
        bidx_d   = '0;
        if (start) begin
          state_d = ST_COLLECT;
          word_d  = '0;
        end
      end

      ST_COLLECT: begin
        if (fifo_re) rd_cnt_d = rd_cnt_q + 1'b1;
        // fifo_data belongs to the read issued in the previous cycle.
        if (rd_pend_q) begin
          bidx_d = bidx_q + 1'b1;
          for (int b = 0; b < BYTES; b++) begin
            if (bidx_q == CNT_W'(SKEW + b)) word_d[8*b +: 8] = fifo_data;
          end
          if (bidx_q == CNT_W'(TOTAL - 1)) state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (word_ready) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign word_data  = word_q;
  assign word_valid = (state_q == ST_HOLD);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_dealignment_collector_n4_w4.sv
// Bench for dealignment_collector_n4_w4: a queue-based lane FIFO with a
// registered read port feeds the collector; a frame-level reference model
// predicts read pulses, start-to-valid latency and the assembled word.
module tb_dealignment_collector_n4_w4;

  localparam int SKEW  = 3;
  localparam int BYTES = 4;
  localparam int TOTAL = SKEW + BYTES;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_re;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dealignment_collector_n4_w4 #(.SKEW(SKEW), .BYTES(BYTES)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_re    (fifo_re),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;

  // Lane FIFO contents and the frame being sent.
  logic [7:0] byte_q[$];
  logic [7:0] frame_b [TOTAL];
  bit         force_empty [64];   // per frame cycle: FIFO reports empty

  // Reference model state for the current frame.
  bit in_frame;
  int frame_cyc;      // cycle number counted from the start cycle (cycle 0)
  int model_reads;    // read pulses the model expects so far
  int last_read_cyc;  // frame cycle of the last expected read
  int act_reads;      // read pulses actually seen on fifo_re

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    fifo_empty = (byte_q.size() == 0) ||
                 (in_frame && frame_cyc < 64 && force_empty[frame_cyc]);
  endtask

  // One clock cycle. Entered and left at the falling edge; fifo_re is
  // compared against the model once inputs have settled, then the FIFO's
  // registered read port answers any read issued in this cycle.
  task automatic step();
    logic re_obs;
    logic exp_re;
    #1;
    exp_re = in_frame && (frame_cyc >= 1) && !fifo_empty && (model_reads < TOTAL);
    check("fifo_re", {31'b0, fifo_re}, {31'b0, exp_re});
    re_obs = fifo_re;
    if (re_obs) act_reads++;
    if (exp_re) begin
      model_reads++;
      last_read_cyc = frame_cyc;
    end
    @(posedge clk);
    @(negedge clk);
    if (re_obs && byte_q.size() > 0) fifo_data = byte_q.pop_front();
    if (in_frame) frame_cyc++;
    update_empty();
  endtask

  task automatic begin_frame();
    foreach (frame_b[i]) byte_q.push_back(frame_b[i]);
    in_frame      = 1'b1;
    frame_cyc     = 0;
    model_reads   = 0;
    last_read_cyc = 0;
    act_reads     = 0;
    update_empty();
  endtask

  task automatic end_frame();
    in_frame = 1'b0;
    foreach (force_empty[i]) force_empty[i] = 1'b0;
    update_empty();
  endtask

  // Full frame: start, wait for the word, optional back-pressure, handshake.
  // exp_lat <= 0 means the latency is taken from the model's read schedule.
  task automatic run_frame(input string tag, input int exp_lat,
                           input int ready_delay, input bit ignore_starts,
                           input bit rnd_ready);
    logic [31:0] exp_word;
    int n;
    for (int b = 0; b < BYTES; b++) exp_word[8*b +: 8] = frame_b[SKEW + b];
    begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"},  {31'b0, busy},       32'd1);
    check({tag, "_done0"}, {31'b0, done},       32'd0);
    check({tag, "_valid0"}, {31'b0, word_valid}, 32'd0);
    n = 0;
    while (!word_valid && n < 300) begin
      start      = ignore_starts && (n == 2);
      word_ready = rnd_ready && (n < 4) && ($urandom_range(0, 1) == 1);
      step();
      n++;
    end
    start      = 1'b0;
    word_ready = 1'b0;
    check({tag, "_valid"},   {31'b0, word_valid}, 32'd1);
    check({tag, "_latency"}, frame_cyc,
          (exp_lat > 0) ? exp_lat : last_read_cyc + 2);
    check({tag, "_word"},    word_data, exp_word);
    for (int i = 0; i < ready_delay; i++) begin
      start = ignore_starts && (i == 0);
      step();
      start = 1'b0;
      check({tag, "_hold_valid"}, {31'b0, word_valid}, 32'd1);
      check({tag, "_hold_word"},  word_data, exp_word);
    end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'b0, word_valid}, 32'd0);
    check({tag, "_idle_busy"},  {31'b0, busy},       32'd0);
    check({tag, "_done"},       {31'b0, done},       32'd1);
    check({tag, "_reads"},      act_reads,           TOTAL);
    end_frame();
  endtask

  initial begin
    int n;
    resetn     = 1'b0;
    start      = 1'b0;
    word_ready = 1'b0;
    fifo_data  = 8'h00;
    in_frame   = 1'b0;
    frame_cyc  = 0;
    update_empty();

    // Reset values.
    #2;
    check("rst_fifo_re",    {31'b0, fifo_re},    32'd0);
    check("rst_word_data",  word_data,           32'd0);
    check("rst_word_valid", {31'b0, word_valid}, 32'd0);
    check("rst_busy",       {31'b0, busy},       32'd0);
    check("rst_done",       {31'b0, done},       32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();

    // Basic frame, FIFO preloaded and never empty.
    frame_b = '{8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame("basic", 9, 0, 1'b0, 1'b0);
    step();
    check("basic_done_pulse", {31'b0, done}, 32'd0);

    // Empty stall: empty for two cycles, three bytes, five-cycle gap, four bytes.
    frame_b = '{8'h5A, 8'hA5, 8'h3C, 8'h04, 8'h03, 8'h02, 8'h01};
    force_empty[1] = 1'b1;
    force_empty[2] = 1'b1;
    for (int c = 6; c <= 10; c++) force_empty[c] = 1'b1;
    run_frame("stall", 9 + 7, 0, 1'b0, 1'b0);
    step();

    // Back-pressure for ten cycles.
    frame_b = '{8'h11, 8'h22, 8'h33, 8'h0D, 8'hF0, 8'hAD, 8'h8B};
    run_frame("bp", 9, 10, 1'b0, 1'b0);
    step();

    // Back-to-back frames, second start in the done cycle.
    frame_b = '{8'hFF, 8'hFF, 8'hFF, 8'h44, 8'h33, 8'h22, 8'h11};
    run_frame("b2b_a", 9, 0, 1'b0, 1'b0);
    frame_b = '{8'h00, 8'h00, 8'h00, 8'h88, 8'h77, 8'h66, 8'h55};
    run_frame("b2b_b", 9, 0, 1'b0, 1'b0);
    step();
    check("b2b_done_pulse", {31'b0, done}, 32'd0);

    // Reset after the fifth read.
    frame_b = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
    begin_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (model_reads < 5 && n < 50) begin
      step();
      n++;
    end
    check("mid_reads_reached", model_reads, 5);
    resetn = 1'b0;
    end_frame();
    #1;
    check("mid_rst_fifo_re",    {31'b0, fifo_re},    32'd0);
    check("mid_rst_word_data",  word_data,           32'd0);
    check("mid_rst_word_valid", {31'b0, word_valid}, 32'd0);
    check("mid_rst_busy",       {31'b0, busy},       32'd0);
    check("mid_rst_done",       {31'b0, done},       32'd0);
    step();
    step();
    resetn = 1'b1;
    byte_q.delete();
    update_empty();
    step();
    check("mid_after_busy", {31'b0, busy}, 32'd0);
    frame_b = '{8'h00, 8'h01, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12};
    run_frame("refill", 9, 0, 1'b0, 1'b0);
    step();

    // start pulsed during COLLECT and HOLD is ignored.
    frame_b = '{8'h9A, 8'h9B, 8'h9C, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
    run_frame("ign", 9, 3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ign_after_busy",  {31'b0, busy},       32'd0);
      check("ign_after_valid", {31'b0, word_valid}, 32'd0);
    end

    // Randomized frames: random payloads, empty gaps and ready delays.
    for (int f = 0; f < 12; f++) begin
      foreach (frame_b[i]) frame_b[i] = 8'($urandom_range(0, 255));
      for (int c = 1; c < 16; c++) force_empty[c] = ($urandom_range(0, 3) == 0);
      run_frame("rnd", 0, $urandom_range(0, 4), 1'b0, 1'b1);
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dealignment_collector_n4_w4.md
# dealignment_collector_n4_w4

Receive-side counterpart of the per-lane data sequencer. It drains one lane's output alignment FIFO byte by byte, discards the leading skew bytes, and reassembles the data bytes into a 32-bit word. The word is delivered on a valid/ready interface. It sits between an array lane's output Circular_FIFO and the SoC result path, one instance per lane.

## Interface
Parameters:
- SKEW, 3, number of leading skew bytes per frame, discarded.
- BYTES, 4, number of data bytes per frame; the word width is 8*BYTES.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  arms collection of one frame; sampled only in IDLE.
- fifo_empty  in  1  lane FIFO empty flag.
- fifo_data  in  8  lane FIFO read data; valid the cycle after fifo_re (registered FIFO output).
- fifo_re  out  1  lane FIFO read enable.
- word_data  out  8*BYTES  reassembled word; byte 0 (first data byte read) is in bits [7:0].
- word_valid  out  1  word_data holds a complete word.
- word_ready  in  1  consumer accepts the word.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the word is accepted.

## Operation
- FSM states and transitions:
  - IDLE: waits for start. start=1 → COLLECT; word_data is cleared to 0 on this transition.
  - COLLECT: issues reads and captures bytes. After the last data byte is captured → HOLD.
  - HOLD: word_valid=1. word_valid && word_ready → IDLE, and done=1 in the following cycle.
- Read issue counter rd_cnt, width clog2(SKEW+BYTES+1):
  - fifo_re = (state==COLLECT) && ~fifo_empty && (rd_cnt < SKEW+BYTES). This is combinational from registers and fifo_empty.
  - rd_cnt increments on each fifo_re and resets to 0 in IDLE.
- Capture:
  - rd_pend is a register that takes the value of fifo_re.
  - On each cycle with rd_pend=1, byte index bidx increments.
  - Bytes with bidx < SKEW are discarded.
  - Otherwise word_data[8*(bidx-SKEW) +: 8] <= fifo_data.
  - Capturing bidx == SKEW+BYTES-1 moves the FSM to HOLD.
- fifo_empty stalls read issue only. Pending captures complete normally. No state is lost, and there is no timeout.
- start outside IDLE is ignored. Frames are never overlapped, and no reads are issued in HOLD.
- word_data is stable from word_valid rising until the handshake completes.
- word_ready while word_valid=0 has no effect.
- Reset mid-operation returns to IDLE and discards partial bytes. The FIFO is not drained.
- Reset values: fifo_re=0, word_data=0, word_valid=0, busy=0, done=0, all counters 0.

## Timing
- Cycle n is the interval after clock edge n.
- With start=1 in cycle 0 and the FIFO never empty:
  - busy=1 from cycle 1.
  - fifo_re=1 in cycles 1..SKEW+BYTES (1..7 at defaults).
  - Captures occur at edges 3..SKEW+BYTES+2.
  - word_valid=1 from cycle SKEW+BYTES+2, i.e. cycle 9 at defaults.
- Start-to-valid latency is SKEW+BYTES+2 cycles. Each empty cycle during COLLECT adds one cycle.
- If word_ready=1 in the first valid cycle:
  - word_valid=0 and busy=0 in the next cycle (IDLE), with done=1 in that same cycle.
  - A new start in that cycle is accepted.
  - Minimum frame period is SKEW+BYTES+3 cycles.
- Back-pressure: word_valid holds indefinitely while word_ready=0.
- Exactly SKEW+BYTES fifo_re pulses are issued per frame, never more.

## Test plan
- Basic frame: preload FIFO with 00,00,00,EF,BE,AD,DE and pulse start → word_valid in cycle 9, word_data=32'hDEADBEEF, 7 fifo_re pulses, done one cycle after the ready handshake.
- Empty stall: FIFO starts empty and 3 bytes arrive, then a 5-cycle gap, then 4 bytes (04,03,02,01) → word_data=32'h01020304, valid delayed by exactly the empty-stall cycles, no fifo_re while fifo_empty=1.
- Back-pressure: word_ready=0 for 10 cycles after valid → word_valid and word_data stable, fifo_re=0 throughout, then accept → IDLE.
- Back-to-back: two frames (11223344 and 55667788 payloads), start re-asserted in the done cycle → two correct words, the second with no stale bytes from the first.
- Reset mid-frame: assert resetn=0 after the 5th read → all outputs 0 immediately (asynchronous); the next frame after re-fill assembles correctly.
- Ignored start: pulse start during COLLECT and HOLD → no extra reads, a single word produced.
